// File: rtl/slave_rx.sv
// -----------------------------------------------------------------------------
// slave_rx
//
// 1-wire style pulse-width receiver. The line idles high. Each low pulse is
// measured in clk cycles and classified by length:
//   shorter than MIN_LOW            -> glitch, ignored
//   MIN_LOW .. SAMPLE_AT            -> bit 1
//   SAMPLE_AT+1 .. RESET_LEN-1      -> bit 0
//   RESET_LEN or longer             -> bus reset
// Eight decoded bits form one byte, least significant bit first.
//
// Parameters
//   SAMPLE_AT  longest low pulse (cycles) decoded as bit 1
//   RESET_LEN  low-pulse length (cycles) treated as a bus reset
//   MIN_LOW    shortest low pulse (cycles) accepted as a bit
//
// Ports
//   clk         single clock, rising-edge
//   rst         asynchronous active-high reset
//   bus_in      raw line from the upstream transmitter, idle high
//   data_out    last completed byte; holds until the next byte or rst
//   data_valid  one-cycle strobe, data_out has just been updated
//   reset_seen  one-cycle strobe, bus reset pulse detected
//   bit_cnt     bits received so far in the current byte
// -----------------------------------------------------------------------------
module slave_rx #(
    parameter int SAMPLE_AT = 15,
    parameter int RESET_LEN = 480,
    parameter int MIN_LOW   = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       bus_in,
    output logic [7:0] data_out,
    output logic       data_valid,
    output logic       reset_seen,
    output logic [2:0] bit_cnt
);

    // state   | meaning
    // IDLE    | line high, waiting for a falling edge
    // LOW     | line low, counting cycles in lcnt
    // RSTLOW  | bus reset already reported, waiting for the line to rise

    localparam int LW = $clog2(RESET_LEN + 1);

    localparam logic [LW-1:0] SAMPLE_AT_C = LW'(SAMPLE_AT);
    localparam logic [LW-1:0] RESET_LEN_C = LW'(RESET_LEN);
    localparam logic [LW-1:0] MIN_LOW_C   = LW'(MIN_LOW);
    localparam logic [LW-1:0] ONE_C       = LW'(1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOW    = 2'd1,
        RSTLOW = 2'd2
    } state_t;

    state_t         state;
    logic           sync_1;
    logic           sbus;
    logic [LW-1:0]  lcnt;
    logic [7:0]     shreg;
    logic           dec_bit;
    logic [7:0]     next_shreg;

    // Both flops reset high so a released reset looks like an idle line;
    // a line already low at release is counted from its first low sbus cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_1 <= 1'b1;
            sbus   <= 1'b1;
        end else begin
            sync_1 <= bus_in;
            sbus   <= sync_1;
        end
    end

    // lcnt holds the number of low cycles seen so far, so on the cycle the
    // rising edge reaches the FSM it equals the full pulse length.
    assign dec_bit    = (lcnt <= SAMPLE_AT_C);
    assign next_shreg = {dec_bit, shreg[7:1]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            lcnt       <= '0;
            shreg      <= 8'h00;
            bit_cnt    <= 3'd0;
            data_out   <= 8'h00;
            data_valid <= 1'b0;
            reset_seen <= 1'b0;
        end else begin
            data_valid <= 1'b0;
            reset_seen <= 1'b0;

            case (state)
                IDLE: begin
                    if (!sbus) begin
                        lcnt  <= ONE_C;
                        state <= LOW;
                    end else begin
                        lcnt  <= '0;
                    end
                end

                LOW: begin
                    if (!sbus) begin
                        // Reset is flagged on the same edge lcnt would reach
                        // RESET_LEN, so the strobe does not wait for the line
                        // to rise.
                        if (lcnt == RESET_LEN_C - ONE_C) begin
                            lcnt       <= RESET_LEN_C;
                            reset_seen <= 1'b1;
                            shreg      <= 8'h00;
                            bit_cnt    <= 3'd0;
                            state      <= RSTLOW;
                        end else begin
                            lcnt <= lcnt + ONE_C;
                        end
                    end else begin
                        state <= IDLE;
                        lcnt  <= '0;
                        if (lcnt >= MIN_LOW_C) begin
                            shreg   <= next_shreg;
                            bit_cnt <= bit_cnt + 3'd1;
                            if (bit_cnt == 3'd7) begin
                                data_out   <= next_shreg;
                                data_valid <= 1'b1;
                            end
                        end
                    end
                end

                RSTLOW: begin
                    // lcnt stays saturated at RESET_LEN until the line rises;
                    // that rising edge carries no bit.
                    if (sbus) begin
                        state <= IDLE;
                        lcnt  <= '0;
                    end
                end

                default: begin
                    state <= IDLE;
                    lcnt  <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_slave_rx.sv
module tb_slave_rx;

    localparam int SAMPLE_AT = 15;
    localparam int RESET_LEN = 480;
    localparam int MIN_LOW   = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       bus_in = 1'b1;
    logic [7:0] data_out;
    logic       data_valid;
    logic       reset_seen;
    logic [2:0] bit_cnt;

    slave_rx #(
        .SAMPLE_AT (SAMPLE_AT),
        .RESET_LEN (RESET_LEN),
        .MIN_LOW   (MIN_LOW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .bus_in     (bus_in),
        .data_out   (data_out),
        .data_valid (data_valid),
        .reset_seen (reset_seen),
        .bit_cnt    (bit_cnt)
    );

    always #5 clk = ~clk;

    // cyc equals the index of the most recent rising edge
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        int         at;
        bit         is_rst;
        logic [7:0] data;
    } ev_t;

    ev_t exp_q[$];
    ev_t mon_e;

    // reference model: bits collected into the current byte
    int         m_cnt  = 0;
    logic [7:0] m_acc  = 8'h00;
    logic [7:0] m_last = 8'h00;
    int         dv_seen = 0;
    int         rs_seen = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (data_valid && reset_seen) check("dv_rs_overlap", 1, 0);
            if (data_valid || reset_seen) begin
                if (data_valid) dv_seen++;
                if (reset_seen) rs_seen++;
                if (exp_q.size() == 0) begin
                    check("unexpected_event", 1, 0);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("event_kind", 32'(reset_seen), 32'(mon_e.is_rst));
                    check("event_cycle", cyc, mon_e.at);
                    if (!mon_e.is_rst) check("event_data", 32'(data_out), 32'(mon_e.data));
                end
            end
        end
    end

    task automatic model_clear();
        m_cnt  = 0;
        m_acc  = 8'h00;
        m_last = 8'h00;
        exp_q.delete();
    endtask

    // One low pulse of n cycles followed by gap high cycles. Called #1 after
    // a rising edge. Expected events are queued before the pulse is driven.
    task automatic pulse(input int n, input int gap);
        int k0;
        bit bitv;
        k0 = cyc;
        if (n >= RESET_LEN) begin
            exp_q.push_back('{k0 + RESET_LEN + 2, 1'b1, 8'h00});
            m_cnt = 0;
            m_acc = 8'h00;
        end else if (n >= MIN_LOW) begin
            bitv  = (n <= SAMPLE_AT);
            m_acc = m_acc | (8'(bitv) << m_cnt);
            m_cnt++;
            if (m_cnt == 8) begin
                exp_q.push_back('{k0 + n + 3, 1'b0, m_acc});
                m_last = m_acc;
                m_cnt  = 0;
                m_acc  = 8'h00;
            end
        end
        bus_in = 1'b0;
        repeat (n) @(posedge clk);
        #1 bus_in = 1'b1;
        if (gap >= 3) begin
            repeat (3) @(posedge clk);
            #1 check("bit_cnt_after_pulse", 32'(bit_cnt), m_cnt);
            repeat (gap - 3) @(posedge clk);
            #1;
        end else begin
            repeat (gap) @(posedge clk);
            #1;
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input int one_len, input int zero_len, input int gap);
        for (int i = 0; i < 8; i++) pulse(b[i] ? one_len : zero_len, gap);
    endtask

    task automatic settle();
        repeat (8) @(posedge clk);
        #1;
        check("no_missing_events", exp_q.size(), 0);
    endtask

    task automatic check_zero(input string name);
        check({name, "_data_out"}, 32'(data_out), 0);
        check({name, "_data_valid"}, 32'(data_valid), 0);
        check({name, "_reset_seen"}, 32'(reset_seen), 0);
        check({name, "_bit_cnt"}, 32'(bit_cnt), 0);
    endtask

    typedef struct {
        string      name;
        logic [7:0] b;
        int         one_len;
        int         zero_len;
        int         gap;
        logic [7:0] exp_data;
    } vec_t;

    vec_t vt[5];

    initial begin
        int dv0, rs0, n, gap, r;
        logic [7:0] tmp;
        bit loop_bits[8];

        vt[0] = '{"a5_6_60",     8'hA5, 6,  60,  10, 8'hA5};
        vt[1] = '{"55_15_16",    8'h55, 15, 16,  10, 8'h55};
        vt[2] = '{"0f_minlen",   8'h0F, 2,  479, 1,  8'h0F};
        vt[3] = '{"b2_backtoback", 8'hB2, 3, 20, 1,  8'hB2};
        vt[4] = '{"e7_mid",      8'hE7, 10, 200, 4,  8'hE7};

        // reset state
        repeat (3) @(posedge clk);
        #1 check_zero("in_reset");
        rst = 1'b0;
        repeat (4) @(posedge clk);
        #1 check_zero("after_release");

        // table-driven bytes
        for (int i = 0; i < 5; i++) begin
            dv0 = dv_seen;
            send_byte(vt[i].b, vt[i].one_len, vt[i].zero_len, vt[i].gap);
            settle();
            check({vt[i].name, "_dv_count"}, dv_seen - dv0, 1);
            check({vt[i].name, "_data_out"}, 32'(data_out), 32'(vt[i].exp_data));
            check({vt[i].name, "_bit_cnt"}, 32'(bit_cnt), 0);
        end

        // glitch between bits of 0x3C
        dv0 = dv_seen;
        tmp = 8'h3C;
        for (int i = 0; i < 4; i++) pulse(tmp[i] ? 6 : 60, 10);
        settle();
        check("glitch_bit_cnt_before", 32'(bit_cnt), 4);
        pulse(1, 10);
        settle();
        check("glitch_bit_cnt_after", 32'(bit_cnt), 4);
        for (int i = 4; i < 8; i++) pulse(tmp[i] ? 6 : 60, 10);
        settle();
        check("glitch_dv_count", dv_seen - dv0, 1);
        check("glitch_data_out", 32'(data_out), 32'h3C);

        // bus reset after 3 bits
        dv0 = dv_seen;
        rs0 = rs_seen;
        pulse(6, 10);
        pulse(60, 10);
        pulse(6, 10);
        pulse(500, 10);
        settle();
        check("busrst_rs_count", rs_seen - rs0, 1);
        check("busrst_dv_count", dv_seen - dv0, 0);
        check("busrst_bit_cnt", 32'(bit_cnt), 0);
        send_byte(8'h81, 6, 60, 10);
        settle();
        check("busrst_next_dv_count", dv_seen - dv0, 1);
        check("busrst_next_data", 32'(data_out), 32'h81);

        // rst two cycles after 5 bits of a byte
        for (int i = 0; i < 5; i++) pulse(i[0] ? 60 : 6, 10);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        model_clear();
        repeat (2) @(posedge clk);
        #1 check_zero("midbyte_rst");
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        dv0 = dv_seen;
        send_byte(8'hF0, 6, 60, 10);
        settle();
        check("rst_next_dv_count", dv_seen - dv0, 1);
        check("rst_next_data", 32'(data_out), 32'hF0);

        // line already low when rst releases
        rst = 1'b1;
        bus_in = 1'b0;
        model_clear();
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        dv0 = dv_seen;
        tmp = 8'h2D;
        pulse(6, 10);
        for (int i = 1; i < 8; i++) pulse(tmp[i] ? 6 : 60, 10);
        settle();
        check("lowrel_dv_count", dv_seen - dv0, 1);
        check("lowrel_data", 32'(data_out), 32'h2D);

        // upstream transmitter loopback, bits in send order
        loop_bits = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        for (int i = 0; i < 8; i++) pulse(loop_bits[i] ? 6 : 60, 10);
        settle();
        check("loopback_data", 32'(data_out), 32'hB6);

        // randomized pulse train against the reference model
        for (int i = 0; i < 300; i++) begin
            r = $urandom_range(0, 99);
            if (r < 8)       n = 1;
            else if (r < 50) n = $urandom_range(2, 15);
            else if (r < 92) n = $urandom_range(16, 120);
            else if (r < 97) n = $urandom_range(440, 479);
            else             n = $urandom_range(480, 530);
            gap = $urandom_range(1, 6);
            pulse(n, gap);
        end
        settle();
        check("random_bit_cnt", 32'(bit_cnt), m_cnt);
        check("random_data_out", 32'(data_out), 32'(m_last));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
